// File: rtl/mem_rmw_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_rmw_ctrl_pkg
// Shared definitions for the load/store data unit and its lane aligner:
//   - MEM_OP_WIDTH and the memory opcode encoding used on req_op
//   - FSM state encoding of mem_rmw_ctrl
//   - helper functions: access size (log2 bytes), store/unsigned/legal decode
// ---------------------------------------------------------------------------
package mem_rmw_ctrl_pkg;

    localparam int MEM_OP_WIDTH = 4;

    typedef enum logic [MEM_OP_WIDTH-1:0] {
        MEM_LB  = 4'd0,
        MEM_LH  = 4'd1,
        MEM_LW  = 4'd2,
        MEM_LD  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_LWU = 4'd6,
        MEM_SB  = 4'd7,
        MEM_SH  = 4'd8,
        MEM_SW  = 4'd9,
        MEM_SD  = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    // log2 of the access size in bytes: 0 byte, 1 half, 2 word, 3 double.
    // Encodings outside the table report double so they are still
    // alignment-checked; they are rejected by op_is_legal anyway.
    function automatic logic [1:0] op_size(input logic [MEM_OP_WIDTH-1:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 2'd0;
            MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
            MEM_LW, MEM_LWU, MEM_SW: return 2'd2;
            default:                 return 2'd3;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [MEM_OP_WIDTH-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW) || (op == MEM_SD);
    endfunction

    function automatic logic op_is_unsigned(input logic [MEM_OP_WIDTH-1:0] op);
        return (op == MEM_LBU) || (op == MEM_LHU) || (op == MEM_LWU);
    endfunction

    function automatic logic op_is_legal(input logic [MEM_OP_WIDTH-1:0] op);
        return op <= MEM_SD;
    endfunction

endpackage

// File: rtl/mem_rmw_ctrl_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane helper, shared with the D-cache fill path.
//   op          : memory opcode (selects size and signedness)
//   lane        : byte offset of the access inside the word
//   old_word    : word read from RAM
//   wdata       : LSB-justified store data
//   merged_word : old_word with the store lane(s) replaced by wdata
//   load_data   : old_word shifted down by lane, truncated and extended
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_rmw_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W / 8)
)
(
    input  logic [MEM_OP_WIDTH-1:0] op,
    input  logic [LANE_W-1:0]       lane,
    input  logic [DATA_W-1:0]       old_word,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       merged_word,
    output logic [DATA_W-1:0]       load_data
);

    localparam int NB  = DATA_W / 8;
    localparam int SHW = $clog2(DATA_W);

    logic [1:0]        size;
    logic [6:0]        acc_bits;
    logic [NB-1:0]     byte_mask;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata_sh;
    logic [DATA_W-1:0] low_mask;
    logic [SHW-1:0]    sign_idx;
    logic              sign_bit;

    always_comb begin
        size     = op_size(op);
        acc_bits = 7'd8 << size;

        // Bytes covered by the access. When the access spans the whole word
        // the shift wraps to zero and the subtraction yields all ones.
        byte_mask = ((NB'(1) << (4'd1 << size)) - NB'(1)) << lane;
        wdata_sh  = wdata << {lane, 3'b000};

        rdata_sh  = old_word >> {lane, 3'b000};
        // Same wrap trick: a full-width access keeps every bit.
        low_mask  = (DATA_W'(1) << acc_bits) - DATA_W'(1);
        // Clamp keeps the index in range for encodings wider than the word.
        sign_idx  = (acc_bits > 7'(DATA_W)) ? SHW'(DATA_W - 1) : SHW'(acc_bits - 7'd1);
        sign_bit  = rdata_sh[sign_idx] & ~op_is_unsigned(op);
        load_data = (rdata_sh & low_mask) | ({DATA_W{sign_bit}} & ~low_mask);
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign merged_word[8*gi +: 8] = byte_mask[gi] ? wdata_sh[8*gi +: 8]
                                                      : old_word[8*gi +: 8];
    end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// mem_rmw_ctrl
// Load/store data unit between the LSU and a word-wide RAM without byte
// enables. Partial stores are done as read-modify-write, full-word stores
// are written directly, loads are lane-extracted and sign/zero-extended.
// Misaligned or unsupported requests answer with rsp_err and never touch RAM.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_vld/req_rdy                 request handshake
//   req_op/req_addr/req_wdata       opcode, byte address, LSB-justified data
//   rsp_vld/rsp_rdy                 response handshake
//   rsp_rdata/rsp_err               extended load data (0 otherwise), error
//   mem_en/mem_we                   RAM strobe and write enable
//   mem_addr/mem_wdata/mem_rdata    word-aligned address, write/read words
//
// All outputs are registers; nothing on req_* reaches mem_* combinationally.
// ---------------------------------------------------------------------------
module mem_rmw_ctrl
    import mem_rmw_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic [MEM_OP_WIDTH-1:0] req_op,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int         LANE_W    = $clog2(DATA_W / 8);
    localparam logic [1:0] FULL_SIZE = (DATA_W == 64) ? 2'd3 : 2'd2;

    // Captured request and FSM state
    state_e                  state_reg;
    logic [MEM_OP_WIDTH-1:0] op_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [LANE_W-1:0]       lane_reg;
    logic [2:0]              cnt_reg;
    logic [DATA_W-1:0]       rbuf_reg;

    // Registered outputs
    logic                    req_rdy_reg;
    logic                    rsp_vld_reg;
    logic                    rsp_err_reg;
    logic [DATA_W-1:0]       rsp_rdata_reg;
    logic                    mem_en_reg;
    logic                    mem_we_reg;
    logic [ADDR_W-1:0]       mem_addr_reg;
    logic [DATA_W-1:0]       mem_wdata_reg;

    // Accept-time decode of the incoming request
    logic [1:0]              req_size;
    logic                    req_misaligned;
    logic                    req_unsupported;
    logic                    req_error;
    logic                    req_full_store;

    // Read-capture path
    logic                    rd_capture;
    logic [DATA_W-1:0]       rbuf_next;
    logic [DATA_W-1:0]       merged_word;
    logic [DATA_W-1:0]       load_data;

    always_comb begin
        req_size = op_size(req_op);
        case (req_size)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = |req_addr[2:0];
        endcase
        req_unsupported = !op_is_legal(req_op) ||
                          ((DATA_W == 32) &&
                           ((req_op == MEM_LD) || (req_op == MEM_SD) || (req_op == MEM_LWU)));
        req_error       = req_misaligned || req_unsupported;
        req_full_store  = op_is_store(req_op) && (req_size == FULL_SIZE);
    end

    // The RAM word is aligned in the same cycle it is captured so that the
    // merged write word and the extended load value are ready as registers
    // on the following cycle.
    assign rd_capture = (state_reg == ST_RD) && (cnt_reg == 3'(RD_LAT));
    assign rbuf_next  = rd_capture ? mem_rdata : rbuf_reg;

    mem_lane_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_align (
        .op          (op_reg),
        .lane        (lane_reg),
        .old_word    (rbuf_next),
        .wdata       (wdata_reg),
        .merged_word (merged_word),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            wdata_reg     <= '0;
            lane_reg      <= '0;
            cnt_reg       <= '0;
            rbuf_reg      <= '0;
            req_rdy_reg   <= 1'b1;
            rsp_vld_reg   <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_vld) begin
                        op_reg        <= req_op;
                        wdata_reg     <= req_wdata;
                        lane_reg      <= req_addr[LANE_W-1:0];
                        cnt_reg       <= '0;
                        req_rdy_reg   <= 1'b0;
                        rsp_rdata_reg <= '0;
                        if (req_error) begin
                            state_reg   <= ST_RSP;
                            rsp_vld_reg <= 1'b1;
                            rsp_err_reg <= 1'b1;
                        end else begin
                            mem_en_reg   <= 1'b1;
                            mem_addr_reg <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            if (req_full_store) begin
                                state_reg     <= ST_WR;
                                mem_we_reg    <= 1'b1;
                                mem_wdata_reg <= req_wdata;
                            end else begin
                                state_reg     <= ST_RD;
                                mem_we_reg    <= 1'b0;
                            end
                        end
                    end
                end

                ST_RD: begin
                    // Strobe only in the first RD cycle; then wait out the latency.
                    mem_en_reg <= 1'b0;
                    cnt_reg    <= cnt_reg + 3'd1;
                    if (rd_capture) begin
                        cnt_reg  <= '0;
                        rbuf_reg <= mem_rdata;
                        if (op_is_store(op_reg)) begin
                            state_reg     <= ST_WR;
                            mem_en_reg    <= 1'b1;
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= merged_word;
                        end else begin
                            state_reg     <= ST_RSP;
                            rsp_vld_reg   <= 1'b1;
                            rsp_rdata_reg <= load_data;
                        end
                    end
                end

                ST_WR: begin
                    mem_en_reg  <= 1'b0;
                    mem_we_reg  <= 1'b0;
                    state_reg   <= ST_RSP;
                    rsp_vld_reg <= 1'b1;
                end

                ST_RSP: begin
                    if (rsp_rdy) begin
                        state_reg     <= ST_IDLE;
                        req_rdy_reg   <= 1'b1;
                        rsp_vld_reg   <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= '0;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_rdy   = req_rdy_reg;
    assign rsp_vld   = rsp_vld_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule
